xbar_write_port_scheduler: RTL and testbench
============================================

XBAR_WRITE_PORT_SCHEDULER -- requirements
Module: xbar_write_port_scheduler

Interface
REQ-001 SHALL have parameter MASTERS, default 2: number of requesting masters, >=2.
REQ-002 SHALL have parameter ID_WIDTH, default 4: master-side AXI ID width.
REQ-003 SHALL have parameter IDS_WIDTH, default ID_WIDTH+$clog2(MASTERS): slave-side extended ID width.
REQ-004 SHALL have parameters ADDR_WIDTH 32, LEN_WIDTH 4, SIZE_WIDTH 3, DATA_WIDTH 32, STRB_WIDTH DATA_WIDTH/8: AXI payload widths.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4: write transactions in flight toward the slave, power of two, >=2.
REQ-006 Derived widths: AW_W = ID_WIDTH+ADDR_WIDTH+LEN_WIDTH+SIZE_WIDTH+2; W_W = DATA_WIDTH+STRB_WIDTH+1.
REQ-007 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-008 Ports, as name, direction, width, meaning:
- ACLK, in, 1: clock.
- ARESET, in, 1: synchronous active-high reset.
- m_awvalid, in, MASTERS: AW request per master.
- m_awready, out, MASTERS: AW accept per master.
- m_awpayload, in, MASTERS*AW_W: {ID,ADDR,LEN,SIZE,BURST}; master i at slice i.
- m_wvalid, in, MASTERS: W beat valid per master.
- m_wready, out, MASTERS: W beat accept per master.
- m_wpayload, in, MASTERS*W_W: {WDATA,WSTRB,WLAST}; master i at slice i.
- AWVALID_S, out, 1; AWREADY_S, in, 1; AWPAYLOAD_S, out, AW_W-ID_WIDTH+IDS_WIDTH: AW to slave, ID extended.
- WVALID_S, out, 1; WREADY_S, in, 1; WPAYLOAD_S, out, W_W: W to slave.
- BVALID_S, in, 1; BREADY_S, out, 1: B handshake, used only for counting.
- outstanding, out, $clog2(MAX_OUTSTANDING)+1: writes granted but not yet responded.
- err_wlast, out, 1: sticky; WLAST disagreed with the beat count.
- err_b_unexp, out, 1: sticky; B arrived with outstanding==0.

Function
REQ-009 Round-robin arbitration over m_awvalid: search starts at last grant+1 (mod MASTERS); pointer advances only on grant.
REQ-010 Grant condition: AW register empty or draining this cycle (AWREADY_S), order FIFO not full, and outstanding<MAX_OUTSTANDING.
REQ-011 Grant asserts m_awready[g] for the same cycle and loads the AW register; AWVALID_S rises next cycle (1-cycle latency).
REQ-012 AWVALID_S and AWPAYLOAD_S SHALL hold stable until AWREADY_S; back-to-back grants SHALL reach full throughput.
REQ-013 Extended ID SHALL be {zero pad, g, original ID}, with g in $clog2(MASTERS) bits.
REQ-014 Each grant pushes {g, LEN} into the order FIFO (depth MAX_OUTSTANDING) and increments outstanding.
REQ-015 W routing is combinational from the FIFO head master h, with zero added latency:
- WVALID_S = m_wvalid[h] & ~empty.
- m_wready[h] = WREADY_S & ~empty.
- all other m_wready are 0.
- WPAYLOAD_S = slice h.
REQ-016 W beats MAY reach the slave before their AW; this is AXI-legal and SHALL not be blocked.
REQ-017 Beat counter SHALL count W handshakes; at count==LEN the burst is complete: FIFO pop, counter cleared. Completion is set by the count, not by WLAST.
REQ-018 On any handshake where WLAST != (count==LEN), err_wlast SHALL set.
REQ-019 BREADY_S = 1; each B handshake decrements outstanding. On the same cycle as a grant, the net change is 0. With outstanding==0, err_b_unexp sets and the count stays 0.
REQ-020 With order FIFO empty, all m_wready = 0 and WVALID_S = 0.

Reset
REQ-021 On ARESET, all outputs SHALL reset to 0 on the next edge: AWVALID_S, m_awready, m_wready, WVALID_S, outstanding, err_wlast, err_b_unexp.
REQ-022 On ARESET, the RR pointer resets to master 0; the order FIFO and beat counter clear.
REQ-023 Reset mid-burst SHALL drop all in-flight state with no partial handshake after reset.

Structure
REQ-024 Package xbar_pkg SHALL hold AW_W/W_W width functions, the order-entry struct {master, len}, and the extended-ID pack function.
REQ-025 The order FIFO SHALL be sub-module xbar_order_fifo: single-clock, parametrised width/depth, full/empty flags. Arbiter and beat counter stay inline.

Verification
REQ-026 Scenario: M0,M1 both assert AW continuously, AWREADY_S=1 -> grants alternate 0,1,0,1; AWID_S bit4 toggles.
REQ-027 Scenario: 4 grants, no B, MAX_OUTSTANDING=4 -> 5th AW stalls and outstanding=4; one B -> grant next cycle.
REQ-028 Scenario: M1 AW LEN=3 then M0 LEN=0 -> 4 M1 beats on WPAYLOAD_S, then 1 M0 beat; M0 W is blocked until then.
REQ-029 Scenario: LEN=1 burst with WLAST on beat 0 -> err_wlast=1; FIFO still pops after beat 1.
REQ-030 Scenario: grant and B handshake in the same cycle, outstanding=2 -> stays 2; B at 0 -> err_b_unexp=1.
REQ-031 Scenario: ARESET asserted mid-burst (beat 2 of 4) -> next cycle all outputs 0, FIFO empty, RR pointer 0.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared types and helpers for the crossbar write-port scheduler.
package xbar_pkg;

   // Order entries use fixed-width fields so one packed type serves every
   // parameterisation (up to 256 masters and 8-bit burst lengths).
   localparam int ORD_MST_W = 8;
   localparam int ORD_LEN_W = 8;

   // One granted write: which master owns it and how many beats minus one.
   typedef struct packed {
      logic [ORD_MST_W-1:0] master;
      logic [ORD_LEN_W-1:0] len;
   } order_entry_t;

   // Width of an AW payload {ID, ADDR, LEN, SIZE, BURST}.
   function automatic int aw_width(input int id_w, input int addr_w,
                                   input int len_w, input int size_w);
      return id_w + addr_w + len_w + size_w + 2;
   endfunction

   // Width of a W payload {WDATA, WSTRB, WLAST}.
   function automatic int w_width(input int data_w, input int strb_w);
      return data_w + strb_w + 1;
   endfunction

   // Slave-side ID: {zero pad, master index, original ID}. Caller truncates.
   function automatic logic [63:0] pack_ext_id(input logic [31:0] id,
                                                input logic [31:0] master,
                                                input int id_w);
      return (64'(master) << id_w) | 64'(id);
   endfunction

endpackage

// File: rtl/xbar_order_fifo.sv
// Single-clock FIFO holding the AW grant order; DEPTH must be a power of two.
module xbar_order_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   // Entry storage written at the tail.
   // NOTE: storage is not reset; count_q alone decides which entries are valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Pointers and occupancy; pointers wrap naturally because DEPTH is 2^PW.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/xbar_write_port_scheduler.sv
// Arbitrates AW requests from several masters onto one slave port, extends
// the ID with the master index, and steers W beats in grant order.
module xbar_write_port_scheduler
   import xbar_pkg::*;
#(
   parameter int MASTERS         = 2,
   parameter int ID_WIDTH        = 4,
   parameter int IDS_WIDTH       = ID_WIDTH + $clog2(MASTERS),
   parameter int ADDR_WIDTH      = 32,
   parameter int LEN_WIDTH       = 4,
   parameter int SIZE_WIDTH      = 3,
   parameter int DATA_WIDTH      = 32,
   parameter int STRB_WIDTH      = DATA_WIDTH / 8,
   parameter int MAX_OUTSTANDING = 4,
   localparam int AW_W  = aw_width(ID_WIDTH, ADDR_WIDTH, LEN_WIDTH, SIZE_WIDTH),
   localparam int W_W   = w_width(DATA_WIDTH, STRB_WIDTH),
   localparam int AWS_W = AW_W - ID_WIDTH + IDS_WIDTH,
   localparam int OW    = $clog2(MAX_OUTSTANDING) + 1
)(
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic [MASTERS-1:0]        m_awvalid,
   output logic [MASTERS-1:0]        m_awready,
   input  logic [MASTERS*AW_W-1:0]   m_awpayload,
   input  logic [MASTERS-1:0]        m_wvalid,
   output logic [MASTERS-1:0]        m_wready,
   input  logic [MASTERS*W_W-1:0]    m_wpayload,
   output logic                      AWVALID_S,
   input  logic                      AWREADY_S,
   output logic [AWS_W-1:0]          AWPAYLOAD_S,
   output logic                      WVALID_S,
   input  logic                      WREADY_S,
   output logic [W_W-1:0]            WPAYLOAD_S,
   input  logic                      BVALID_S,
   output logic                      BREADY_S,
   output logic [OW-1:0]             outstanding,
   output logic                      err_wlast,
   output logic                      err_b_unexp
);

   localparam int MW     = $clog2(MASTERS);
   localparam int REST_W = AW_W - ID_WIDTH;
   localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

   logic [MW-1:0]        rr_ptr_q, rr_ptr_d;
   logic                 aw_valid_q;
   logic [AWS_W-1:0]     aw_payload_q;
   logic [OW-1:0]        out_q;
   logic [LEN_WIDTH-1:0] beat_q;
   logic                 err_wlast_q, err_b_q;

   logic                 grant_found, can_grant, grant;
   logic [MW-1:0]        grant_idx;
   logic [AW_W-1:0]      sel_aw;
   logic [IDS_WIDTH-1:0] ext_id;
   order_entry_t         push_entry, head_entry;
   logic                 fifo_full, fifo_empty, fifo_pop;
   logic [MW-1:0]        head_mst;
   logic [LEN_WIDTH-1:0] head_len;
   logic [W_W-1:0]       head_w;
   logic                 w_hs, last_beat;

   // Round-robin search for the first requester starting at the pointer.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < MASTERS; k++) begin
         if (!grant_found && m_awvalid[(int'(rr_ptr_q) + k) % MASTERS]) begin
            grant_found = 1'b1;
            grant_idx   = MW'((int'(rr_ptr_q) + k) % MASTERS);
         end
      end
   end

   // Grant only when the AW slot frees up this cycle and both the order
   // queue and the outstanding budget have room; never while in reset.
   assign can_grant = ~ARESET & (~aw_valid_q | AWREADY_S) & ~fifo_full &
                      (out_q < MAX_OUT);
   assign grant     = can_grant & grant_found;
   assign rr_ptr_d  = (int'(grant_idx) == MASTERS - 1) ? '0 : grant_idx + 1'b1;

   // One-hot AW accept toward the granted master.
   always_comb begin
      m_awready = '0;
      if (grant) m_awready[grant_idx] = 1'b1;
   end

   assign sel_aw = m_awpayload[grant_idx*AW_W +: AW_W];
   assign ext_id = IDS_WIDTH'(pack_ext_id(32'(sel_aw[AW_W-1 -: ID_WIDTH]),
                                          32'(grant_idx), ID_WIDTH));
   assign push_entry = '{master: ORD_MST_W'(grant_idx),
                         len:    ORD_LEN_W'(sel_aw[SIZE_WIDTH+2 +: LEN_WIDTH])};

   xbar_order_fifo #(
      .WIDTH ($bits(order_entry_t)),
      .DEPTH (MAX_OUTSTANDING)
   ) u_order_fifo (
      .clk_i       (ACLK),
      .rst_i       (ARESET),
      .push_i      (grant),
      .push_data_i (push_entry),
      .pop_i       (fifo_pop),
      .head_o      (head_entry),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // W steering follows the oldest granted burst; nothing passes when idle.
   assign head_mst   = fifo_empty ? '0 : MW'(head_entry.master);
   assign head_len   = LEN_WIDTH'(head_entry.len);
   assign head_w     = m_wpayload[head_mst*W_W +: W_W];
   assign WVALID_S   = m_wvalid[head_mst] & ~fifo_empty;
   assign WPAYLOAD_S = head_w;
   assign w_hs       = WVALID_S & WREADY_S;
   assign last_beat  = (beat_q == head_len);
   assign fifo_pop   = w_hs & last_beat;

   // W accept goes only to the head master.
   always_comb begin
      m_wready = '0;
      if (!fifo_empty) m_wready[head_mst] = WREADY_S;
   end

   assign AWVALID_S   = aw_valid_q;
   assign AWPAYLOAD_S = aw_payload_q;
   assign BREADY_S    = 1'b1;
   assign outstanding = out_q;
   assign err_wlast   = err_wlast_q;
   assign err_b_unexp = err_b_q;

   // AW output register: loads on grant, holds until the slave accepts.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_valid_q   <= 1'b0;
         aw_payload_q <= '0;
         rr_ptr_q     <= '0;
      end else if (grant) begin
         aw_valid_q   <= 1'b1;
         aw_payload_q <= {ext_id, sel_aw[REST_W-1:0]};
         rr_ptr_q     <= rr_ptr_d;
      end else if (AWREADY_S) begin
         aw_valid_q   <= 1'b0;
      end
   end

   // Beat counter: burst ends on the counted beat; WLAST is only cross-checked.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         beat_q      <= '0;
         err_wlast_q <= 1'b0;
      end else if (w_hs) begin
         beat_q <= last_beat ? '0 : beat_q + 1'b1;
         if (head_w[0] != last_beat) err_wlast_q <= 1'b1;
      end
   end

   // Outstanding count: +1 per grant, -1 per B, floored at zero.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         out_q   <= '0;
         err_b_q <= 1'b0;
      end else begin
         if (BVALID_S && out_q == '0) err_b_q <= 1'b1;
         if (grant && !BVALID_S)                      out_q <= out_q + 1'b1;
         else if (BVALID_S && !grant && out_q != '0)  out_q <= out_q - 1'b1;
      end
   end

endmodule

// File: tb/tb_xbar_write_port_scheduler.sv
// Self-checking bench: directed scenario table and sequences, then random
// traffic compared against a queue-based reference model.
module tb_xbar_write_port_scheduler;

   localparam int M     = 2;
   localparam int IDW   = 4;
   localparam int AW_W  = 45;
   localparam int W_W   = 37;
   localparam int AWS_W = 46;
   localparam int MAXO  = 4;

   logic               ACLK = 1'b0;
   logic               ARESET;
   logic [M-1:0]       m_awvalid, m_awready, m_wvalid, m_wready;
   logic [M*AW_W-1:0]  m_awpayload;
   logic [M*W_W-1:0]   m_wpayload;
   logic               AWVALID_S, AWREADY_S, WVALID_S, WREADY_S;
   logic               BVALID_S, BREADY_S;
   logic [AWS_W-1:0]   AWPAYLOAD_S;
   logic [W_W-1:0]     WPAYLOAD_S;
   logic [2:0]         outstanding;
   logic               err_wlast, err_b_unexp;

   int checks = 0;
   int failures = 0;

   xbar_write_port_scheduler dut (
      .ACLK        (ACLK),
      .ARESET      (ARESET),
      .m_awvalid   (m_awvalid),
      .m_awready   (m_awready),
      .m_awpayload (m_awpayload),
      .m_wvalid    (m_wvalid),
      .m_wready    (m_wready),
      .m_wpayload  (m_wpayload),
      .AWVALID_S   (AWVALID_S),
      .AWREADY_S   (AWREADY_S),
      .AWPAYLOAD_S (AWPAYLOAD_S),
      .WVALID_S    (WVALID_S),
      .WREADY_S    (WREADY_S),
      .WPAYLOAD_S  (WPAYLOAD_S),
      .BVALID_S    (BVALID_S),
      .BREADY_S    (BREADY_S),
      .outstanding (outstanding),
      .err_wlast   (err_wlast),
      .err_b_unexp (err_b_unexp)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW_W-1:0] mk_aw(input logic [3:0] id, input logic [31:0] addr,
                                            input logic [3:0] len);
      return {id, addr, len, 3'd2, 2'b01};
   endfunction

   function automatic logic [W_W-1:0] mk_w(input logic [31:0] data, input logic last);
      return {data, 4'hF, last};
   endfunction

   task automatic set_aw(input int i, input logic [3:0] id, input logic [3:0] len);
      m_awpayload[i*AW_W +: AW_W] = mk_aw(id, 32'h1000_0000 + 32'(i*256), len);
   endtask

   task automatic set_w(input int i, input logic [31:0] data, input logic last);
      m_wpayload[i*W_W +: W_W] = mk_w(data, last);
   endtask

   task automatic idle_inputs();
      m_awvalid = '0; m_awpayload = '0; m_wvalid = '0; m_wpayload = '0;
      AWREADY_S = 1'b0; WREADY_S = 1'b0; BVALID_S = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge ACLK);
      #1;
   endtask

   task automatic reset_dut();
      idle_inputs();
      ARESET = 1'b1;
      next_cycle();
      next_cycle();
      ARESET = 1'b0;
   endtask

   // Directed table for alternating round-robin grants.
   typedef struct {
      logic [1:0] awv;
      logic       bv;
      logic [1:0] exp_awready;
      logic       exp_awvalid;
      logic       exp_idb;
      logic       exp_wvalid;
      logic [1:0] exp_wready;
      logic [2:0] exp_out;
   } vec_t;

   // Reference model state.
   typedef struct { int master; int len; } ord_t;
   ord_t             mq[$];
   int               m_out, m_beat, m_ptr;
   bit               m_awv, m_ew, m_eb;
   logic [AWS_W-1:0] m_awp;

   initial begin
      vec_t tbl[5];
      tbl[0] = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0};
      tbl[1] = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 2'b01, 3'd1};
      tbl[2] = '{2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 2'b10, 3'd1};
      tbl[3] = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 2'b01, 3'd1};
      tbl[4] = '{2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 2'b10, 3'd1};

      // Reset state.
      ARESET = 1'b1;
      idle_inputs();
      reset_dut();
      @(negedge ACLK);
      check("rst_awvalid", 64'(AWVALID_S), 0);
      check("rst_awready", 64'(m_awready), 0);
      check("rst_wvalid", 64'(WVALID_S), 0);
      check("rst_wready", 64'(m_wready), 0);
      check("rst_outstanding", 64'(outstanding), 0);
      check("rst_errs", 64'({err_wlast, err_b_unexp}), 0);
      check("rst_bready", 64'(BREADY_S), 1);
      next_cycle();

      // Alternating grants with continuous AW from both masters.
      reset_dut();
      set_aw(0, 4'h3, 4'd0);
      set_aw(1, 4'hA, 4'd0);
      set_w(0, 32'h0000_00AA, 1'b1);
      set_w(1, 32'h0000_00BB, 1'b1);
      AWREADY_S = 1'b1; WREADY_S = 1'b1; m_wvalid = 2'b11;
      for (int i = 0; i < 5; i++) begin
         m_awvalid = tbl[i].awv;
         BVALID_S  = tbl[i].bv;
         @(negedge ACLK);
         check("rr_awready", 64'(m_awready), 64'(tbl[i].exp_awready));
         check("rr_awvalid_s", 64'(AWVALID_S), 64'(tbl[i].exp_awvalid));
         if (tbl[i].exp_awvalid)
            check("rr_id_master_bit", 64'(AWPAYLOAD_S[AWS_W-1]), 64'(tbl[i].exp_idb));
         if (i == 2)
            check("rr_ext_payload", 64'(AWPAYLOAD_S),
                  64'({1'b1, mk_aw(4'hA, 32'h1000_0100, 4'd0)}));
         check("rr_wvalid_s", 64'(WVALID_S), 64'(tbl[i].exp_wvalid));
         check("rr_wready", 64'(m_wready), 64'(tbl[i].exp_wready));
         check("rr_outstanding", 64'(outstanding), 64'(tbl[i].exp_out));
         next_cycle();
      end

      // Outstanding limit stalls the fifth AW; a B releases it.
      reset_dut();
      set_aw(0, 4'h2, 4'd0);
      set_w(0, 32'h1234_5678, 1'b1);
      m_awvalid = 2'b01; AWREADY_S = 1'b1; m_wvalid = 2'b01; WREADY_S = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge ACLK);
         check("lim_grant", 64'(m_awready), 64'(2'b01));
         check("lim_count", 64'(outstanding), 64'(c));
         next_cycle();
      end
      @(negedge ACLK);
      check("lim_stall", 64'(m_awready), 0);
      check("lim_full_count", 64'(outstanding), 4);
      next_cycle();
      BVALID_S = 1'b1;
      @(negedge ACLK);
      check("lim_stall_b", 64'(m_awready), 0);
      check("lim_aw_drained", 64'(AWVALID_S), 0);
      check("lim_w_idle", 64'(WVALID_S), 0);
      next_cycle();
      BVALID_S = 1'b0;
      @(negedge ACLK);
      check("lim_after_b_count", 64'(outstanding), 3);
      check("lim_after_b_grant", 64'(m_awready), 64'(2'b01));
      next_cycle();

      // W ordering: M1 LEN=3 burst fully precedes M0 LEN=0.
      reset_dut();
      set_aw(1, 4'h5, 4'd3);
      set_aw(0, 4'h6, 4'd0);
      AWREADY_S = 1'b1; WREADY_S = 1'b1; m_awvalid = 2'b10;
      @(negedge ACLK);
      check("ord_grant_m1", 64'(m_awready), 64'(2'b10));
      next_cycle();
      m_awvalid = 2'b01; m_wvalid = 2'b11;
      set_w(0, 32'hA0A0_0000, 1'b1);
      for (int b = 0; b < 4; b++) begin
         set_w(1, 32'hB000_0000 + 32'(b), (b == 3));
         @(negedge ACLK);
         if (b == 0) check("ord_grant_m0", 64'(m_awready), 64'(2'b01));
         check("ord_m1_wready", 64'(m_wready), 64'(2'b10));
         check("ord_m1_beat", 64'(WPAYLOAD_S), 64'(mk_w(32'hB000_0000 + 32'(b), (b == 3))));
         next_cycle();
         m_awvalid = 2'b00;
      end
      @(negedge ACLK);
      check("ord_m0_wready", 64'(m_wready), 64'(2'b01));
      check("ord_m0_beat", 64'(WPAYLOAD_S), 64'(mk_w(32'hA0A0_0000, 1'b1)));
      check("ord_m0_wvalid", 64'(WVALID_S), 1);
      next_cycle();
      @(negedge ACLK);
      check("ord_empty_wvalid", 64'(WVALID_S), 0);
      check("ord_empty_wready", 64'(m_wready), 0);
      check("ord_no_err", 64'(err_wlast), 0);
      next_cycle();

      // Early WLAST flags an error but the count still decides completion.
      reset_dut();
      set_aw(0, 4'h1, 4'd1);
      m_awvalid = 2'b01; AWREADY_S = 1'b1;
      @(negedge ACLK);
      check("wl_grant", 64'(m_awready), 64'(2'b01));
      next_cycle();
      m_awvalid = 2'b00; m_wvalid = 2'b01; WREADY_S = 1'b1;
      set_w(0, 32'hC0, 1'b1);
      @(negedge ACLK);
      check("wl_before", 64'(err_wlast), 0);
      next_cycle();
      set_w(0, 32'hC1, 1'b1);
      @(negedge ACLK);
      check("wl_set", 64'(err_wlast), 1);
      check("wl_still_open", 64'(m_wready), 64'(2'b01));
      next_cycle();
      @(negedge ACLK);
      check("wl_popped_wready", 64'(m_wready), 0);
      check("wl_popped_wvalid", 64'(WVALID_S), 0);
      check("wl_sticky", 64'(err_wlast), 1);
      next_cycle();

      // Grant and B in the same cycle; then B with nothing outstanding.
      reset_dut();
      set_aw(0, 4'h1, 4'd0);
      m_awvalid = 2'b01; AWREADY_S = 1'b1;
      next_cycle();
      next_cycle();
      BVALID_S = 1'b1;
      @(negedge ACLK);
      check("gb_grant", 64'(m_awready), 64'(2'b01));
      check("gb_before", 64'(outstanding), 2);
      next_cycle();
      m_awvalid = 2'b00;
      @(negedge ACLK);
      check("gb_net_zero", 64'(outstanding), 2);
      next_cycle();
      next_cycle();
      @(negedge ACLK);
      check("gb_zero", 64'(outstanding), 0);
      check("gb_no_err_yet", 64'(err_b_unexp), 0);
      next_cycle();
      BVALID_S = 1'b0;
      @(negedge ACLK);
      check("gb_unexp", 64'(err_b_unexp), 1);
      check("gb_floor", 64'(outstanding), 0);
      next_cycle();

      // Reset mid-burst clears everything and the RR pointer.
      reset_dut();
      set_aw(0, 4'h7, 4'd3);
      set_aw(1, 4'h8, 4'd0);
      m_awvalid = 2'b01;
      @(negedge ACLK);
      check("mr_grant", 64'(m_awready), 64'(2'b01));
      next_cycle();
      m_awvalid = 2'b00; m_wvalid = 2'b01; WREADY_S = 1'b1;
      set_w(0, 32'hD0, 1'b1);
      next_cycle();
      set_w(0, 32'hD1, 1'b0);
      @(negedge ACLK);
      check("mr_err_before", 64'(err_wlast), 1);
      check("mr_aw_held", 64'(AWVALID_S), 1);
      check("mr_out_before", 64'(outstanding), 1);
      next_cycle();
      set_w(0, 32'hD2, 1'b0);
      ARESET = 1'b1; m_awvalid = 2'b11;
      next_cycle();
      ARESET = 1'b0; m_awvalid = 2'b00;
      @(negedge ACLK);
      check("mr_awvalid", 64'(AWVALID_S), 0);
      check("mr_awready", 64'(m_awready), 0);
      check("mr_wready", 64'(m_wready), 0);
      check("mr_wvalid", 64'(WVALID_S), 0);
      check("mr_outstanding", 64'(outstanding), 0);
      check("mr_errs", 64'({err_wlast, err_b_unexp}), 0);
      next_cycle();
      m_awvalid = 2'b11; AWREADY_S = 1'b1;
      @(negedge ACLK);
      check("mr_rr_ptr0", 64'(m_awready), 64'(2'b01));
      next_cycle();

      // Random traffic against the reference model.
      reset_dut();
      mq.delete();
      m_out = 0; m_beat = 0; m_ptr = 0; m_awv = 0; m_ew = 0; m_eb = 0; m_awp = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int g, h;
         logic [AW_W-1:0] p;
         bit rst;
         rst = ($urandom_range(0, 299) == 0);
         ARESET    = rst;
         m_awvalid = 2'($urandom);
         m_wvalid  = 2'($urandom);
         AWREADY_S = ($urandom_range(0, 3) != 0);
         WREADY_S  = ($urandom_range(0, 3) != 0);
         BVALID_S  = (m_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
         for (int i = 0; i < M; i++) begin
            logic lst;
            m_awpayload[i*AW_W +: AW_W] = mk_aw(4'($urandom), $urandom, 4'($urandom_range(0, 3)));
            lst = 1'($urandom);
            if (mq.size() > 0 && mq[0].master == i)
               lst = (m_beat == mq[0].len) ^ ($urandom_range(0, 49) == 0);
            set_w(i, $urandom, lst);
         end
         @(negedge ACLK);

         g = -1;
         if (!rst && (!m_awv || AWREADY_S) && mq.size() < MAXO && m_out < MAXO)
            for (int k = 0; k < M; k++)
               if (g < 0 && m_awvalid[(m_ptr + k) % M]) g = (m_ptr + k) % M;
         h = (mq.size() > 0) ? mq[0].master : -1;

         check("rnd_awready", 64'(m_awready), (g >= 0) ? 64'(1) << g : 64'(0));
         check("rnd_awvalid_s", 64'(AWVALID_S), 64'(m_awv));
         if (m_awv) check("rnd_awpayload_s", 64'(AWPAYLOAD_S), 64'(m_awp));
         check("rnd_wvalid_s", 64'(WVALID_S), (h >= 0) ? 64'(m_wvalid[h]) : 64'(0));
         check("rnd_wready", 64'(m_wready), (h >= 0 && WREADY_S) ? 64'(1) << h : 64'(0));
         if (h >= 0) check("rnd_wpayload_s", 64'(WPAYLOAD_S), 64'(m_wpayload[h*W_W +: W_W]));
         check("rnd_outstanding", 64'(outstanding), 64'(m_out));
         check("rnd_err_wlast", 64'(err_wlast), 64'(m_ew));
         check("rnd_err_b_unexp", 64'(err_b_unexp), 64'(m_eb));

         if (rst) begin
            mq.delete();
            m_out = 0; m_beat = 0; m_ptr = 0; m_awv = 0; m_ew = 0; m_eb = 0;
         end else begin
            if (h >= 0 && m_wvalid[h] && WREADY_S) begin
               bit last;
               last = (m_beat == mq[0].len);
               if (m_wpayload[h*W_W] != last) m_ew = 1;
               if (last) begin
                  void'(mq.pop_front());
                  m_beat = 0;
               end else begin
                  m_beat++;
               end
            end
            if (m_awv && AWREADY_S) m_awv = 0;
            if (g >= 0) begin
               p = m_awpayload[g*AW_W +: AW_W];
               m_awv = 1;
               m_awp = (AWS_W'(g) << AW_W) | AWS_W'(p);
               mq.push_back('{g, int'((p >> 5) & 15)});
               m_ptr = (g + 1) % M;
            end
            if (BVALID_S && m_out == 0) m_eb = 1;
            m_out = m_out + ((g >= 0) ? 1 : 0) - (BVALID_S ? 1 : 0);
            if (m_out < 0) m_out = 0;
         end
         next_cycle();
      end
      ARESET = 1'b0;
      idle_inputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
